// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
package instr_fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] PC_STEP          = 64'd4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        Q_IDLE = 2'b00,
        Q_POP  = 2'b01,
        Q_PUSH = 2'b10,
        Q_BOTH = 2'b11
    } queue_op_e;

    function automatic logic [63:0] next_pc(input logic [63:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bundle: redirect, program memory port and decode-side dequeue port.
interface instr_fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          redirect;
    logic [63:0]   redirect_pc;
    logic [63:0]   imem_addr;
    logic [31:0]   imem_instr;
    logic          deq_ready;
    logic          deq_valid;
    logic [63:0]   deq_pc;
    logic [31:0]   deq_instr;
    logic [CW-1:0] count;

    modport master (
        output redirect, redirect_pc, imem_instr, deq_ready,
        input  imem_addr, deq_valid, deq_pc, deq_instr, count
    );

    modport slave (
        input  redirect, redirect_pc, imem_instr, deq_ready,
        output imem_addr, deq_valid, deq_pc, deq_instr, count
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Circular buffer of {pc, instr} entries with flush; reset beats flush beats push/pop.
module fetch_queue_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 wr_entry,
    output fetch_entry_t                 head_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          do_push;
    logic          do_pop;
    queue_op_e     op;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign op      = queue_op_e'({do_push, do_pop});

    assign head_entry = mem[head];

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[tail] <= wr_entry;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PW'(1);
            if (do_pop)  head <= head + PW'(1);
            case (op)
                Q_PUSH:  count <= count + CW'(1);
                Q_POP:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetch queue top: owns fetch_pc, applies redirect priority and drives NOP when empty.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              systemClock,
    input  logic              reset,
    instr_fetch_queue_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [63:0]   fetch_pc;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] occupancy;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head_entry;

    assign pop      = ~empty & bus.deq_ready;
    assign push     = ~full | pop;
    assign wr_entry = '{pc: fetch_pc, instr: bus.imem_instr};

    // Without a push the same address is simply re-fetched next cycle.
    always_ff @(posedge systemClock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
        end else if (push) begin
            fetch_pc <= next_pc(fetch_pc);
        end
    end

    fetch_queue_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (systemClock),
        .rst        (reset),
        .flush      (bus.redirect),
        .push       (push),
        .pop        (pop),
        .wr_entry   (wr_entry),
        .head_entry (head_entry),
        .count      (occupancy),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        bus.imem_addr = fetch_pc;
        bus.count     = occupancy;
        bus.deq_valid = ~empty;
        bus.deq_pc    = '0;
        bus.deq_instr = NOP_INSTR;
        if (!empty) begin
            bus.deq_pc    = head_entry.pc;
            bus.deq_instr = head_entry.instr;
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction prefetch queue between program memory and the IF/ID pipeline register. Owns the fetch PC, reads one 32-bit instruction per cycle from the combinational program memory, and buffers {pc, instruction} pairs in a small FIFO. The decode side drains the FIFO under the hazard unit's IF/ID write-enable. A redirect from branch resolution or misprediction flushes the queue and restarts fetch.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2
- RESET_PC, 64'h0: fetch PC after reset
- systemClock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- redirect  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  64  new fetch address
- imem_addr  out  64  fetch address to program memory; equals fetch_pc
- imem_instr  in  32  instruction at imem_addr, valid in the same cycle
- deq_ready  in  1  consumer accepts the head entry (IF/ID write enable)
- deq_valid  out  1  head entry valid
- deq_pc  out  64  PC of the head entry
- deq_instr  out  32  instruction of the head entry
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- State: fetch_pc (64b), storage of DEPTH×{64b pc, 32b instr}, head and tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), and count.
- pop = deq_valid & deq_ready.
- push = (count < DEPTH) | pop. A full queue accepts a push when a pop happens in the same cycle.
- On push, the queue writes {fetch_pc, imem_instr} at tail, advances tail, and sets fetch_pc <= fetch_pc + 4. The add wraps modulo 2^64.
- On pop, the head pointer advances.
- Count update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- When no push occurs, fetch_pc holds. The same address is re-fetched next cycle.
- Update priority: reset > redirect > push/pop.
- Redirect:
  - head, tail and count clear to 0; fetch_pc <= redirect_pc.
  - The instruction fetched in the redirect cycle is discarded.
  - A pop in the redirect cycle is still honoured by the consumer but has no effect on queue state.
- Outputs are combinational from the head entry:
  - deq_valid = (count != 0).
  - When empty: deq_pc = 0 and deq_instr = 32'h00000013 (NOP, addi x0,x0,0).
- No instruction decode or prediction happens inside the block. Predicted targets arrive through redirect.

## Timing
- Reset values: fetch_pc = RESET_PC, count = 0, deq_valid = 0, deq_pc = 0, deq_instr = NOP, imem_addr = RESET_PC.
- Fetch-to-dequeue latency is 1 cycle. An instruction fetched in cycle N is visible at the head in cycle N+1 if the queue was empty.
- After reset or redirect is deasserted, deq_valid rises one cycle later.
- Steady state with deq_ready held high: one instruction per cycle, count stays at 1.
- With deq_ready low, the queue fills in DEPTH cycles. After that, imem_addr holds at the next unfetched PC.
- Redirect asserted in consecutive cycles: the last redirect_pc wins and the queue stays empty throughout.
- Reset asserted mid-operation overrides everything, including a simultaneous redirect.
- Pointer wrap: no entry is lost or duplicated across the DEPTH-1 → 0 transition.

## Structure
- Shared package constants: NOP_INSTR = 32'h00000013, PC_STEP = 4, and the default RESET_PC.
- One sub-module, fetch_queue_fifo: parameterised storage plus pointer/count logic with push, pop and flush inputs.
- The top holds fetch_pc, redirect priority and the NOP/empty output muxing.

## Test plan
- Reset, then deq_ready = 1 for 6 cycles → deq_pc = 0, 4, 8, 12, 16 on consecutive cycles from cycle 1; deq_instr matches memory; count = 1.
- deq_ready = 0 for 6 cycles after reset → count saturates at 4; imem_addr holds at 16; entries later dequeue as pcs 0, 4, 8, 12 and then 16.
- Full queue with deq_ready = 1 → push and pop in the same cycle; count stays 4; pcs stay contiguous.
- Redirect to 64'h100 while count = 3 → next cycle count = 0 and deq_instr = NOP; the cycle after, deq_pc = 64'h100.
- Redirect and reset in the same cycle → state equals reset state (fetch_pc = RESET_PC).
- Run 10 pushes and pops across the pointer wrap with random deq_ready → the dequeued pc sequence is strictly +4 with no gaps or repeats.
